// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer for the memory stage.
// Walks an 8-bit register list lowest-first and issues one memory transfer per set bit.
module lmsm_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [7:0]        imm8,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done,
    output logic [3:0]        xfer_count
);

    // state | meaning
    // IDLE  | waiting for start, all strobes low
    // XFER  | one transfer per acked cycle, pipeline stalled
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        mask, mask_nxt, mask_clr;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic              op, op_nxt;
    logic [3:0]        count, count_nxt;
    logic [2:0]        low_idx;

    // Lowest set bit wins, so scan from the top and let lower bits overwrite.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    assign mask_clr   = mask & ~(8'd1 << low_idx);
    assign xfer_count = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mask  <= 8'd0;
            addr  <= '0;
            op    <= 1'b0;
            count <= 4'd0;
        end else begin
            state <= state_nxt;
            mask  <= mask_nxt;
            addr  <= addr_nxt;
            op    <= op_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        addr_nxt  = addr;
        op_nxt    = op;
        count_nxt = count;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_addr   = 3'd0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    count_nxt = 4'd0;
                    if (imm8 != 8'd0) begin
                        mask_nxt  = imm8;
                        addr_nxt  = base_addr;
                        op_nxt    = is_store;
                        state_nxt = XFER;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = op;
                mem_addr = addr;
                rf_addr  = low_idx;
                if (op) begin
                    mem_wdata = rf_rd_data;
                end else if (mem_ack) begin
                    rf_we    = 1'b1;
                    rf_wdata = mem_rd_data;
                end
                if (mem_ack) begin
                    mask_nxt  = mask_clr;
                    addr_nxt  = addr + ADDR_W'(1);
                    count_nxt = count + 4'd1;
                    if (mask_clr == 8'd0) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: expected transfers are queued at start and
// popped on every acked XFER cycle.
module tb_lmsm_sequencer;
    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset, start, is_store, mem_ack;
    logic [7:0]    imm8;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] rf_rd_data, mem_rd_data;
    logic          mem_req, mem_we, rf_we, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rf_wdata;
    logic [2:0]    rf_addr;
    logic [3:0]    xfer_count;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [2:0]    ra;
        logic [DW-1:0] data;
    } xfer_t;

    xfer_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    lmsm_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store), .imm8(imm8),
        .base_addr(base_addr), .rf_rd_data(rf_rd_data), .mem_rd_data(mem_rd_data),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .busy(busy), .done(done), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    // Register file and memory models with recognisable contents.
    assign rf_rd_data  = 16'h5A00 + {13'd0, rf_addr};
    assign mem_rd_data = 16'hA000 + mem_addr;

    task automatic push_model(input logic st, input logic [7:0] m, input logic [AW-1:0] base);
        logic [AW-1:0] a;
        xfer_t         t;
        a = base;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
                t.we   = st;
                t.addr = a;
                t.ra   = 3'(k);
                t.data = st ? (16'h5A00 + DW'(k)) : (16'hA000 + a);
                sb.push_back(t);
                a = a + AW'(1);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if ({mem_req, mem_we, rf_we, busy, done} !== 5'b0 || mem_addr !== '0 ||
            mem_wdata !== '0 || rf_addr !== 3'd0 || rf_wdata !== '0 || xfer_count !== 4'd0) begin
            n_bad++;
            $display("FAIL %s: req=%b we=%b rfwe=%b busy=%b done=%b addr=%h wd=%h ra=%0d rfwd=%h cnt=%0d, required all 0",
                     tag, mem_req, mem_we, rf_we, busy, done, mem_addr, mem_wdata, rf_addr, rf_wdata, xfer_count);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_seq(input logic st, input logic [7:0] m, input logic [AW-1:0] base,
                           input int stall_first, input int stall_pct, input bit hold_start,
                           input int exp_done);
        int    cycle, stalls, n, want_done, sf;
        bit    fin;
        xfer_t e;
        n  = $countones(m);
        sf = stall_first;
        sb.delete();
        push_model(st, m, base);

        @(posedge clk); #1;
        start = 1'b1; is_store = st; imm8 = m; base_addr = base;
        mem_ack = 1'($urandom_range(0, 1));
        #1;
        n_cmp++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_start_idle: busy=%b req=%b, required 0/0", busy, mem_req);
        end

        @(posedge clk); #1;
        cycle = 1; stalls = 0; fin = 1'b0;
        while (!fin && cycle <= 200) begin
            if (!hold_start) start = 1'b0;
            imm8 = 8'($urandom); base_addr = AW'($urandom); is_store = 1'($urandom);
            if (sf > 0) begin
                mem_ack = 1'b0;
                sf--;
            end else begin
                mem_ack = ($urandom_range(0, 99) >= stall_pct);
            end
            #1;
            if (done === 1'b1) begin
                fin = 1'b1;
                want_done = (exp_done >= 0) ? exp_done : n + stalls + 1;
                n_cmp++;
                if (cycle != want_done) begin
                    n_bad++;
                    $display("FAIL done_cycle: done in cycle %0d, required cycle %0d", cycle, want_done);
                end
                n_cmp++;
                if (sb.size() != 0) begin
                    n_bad++;
                    $display("FAIL missing_xfers: %0d transfers outstanding, required 0", sb.size());
                end
                n_cmp++;
                if (xfer_count !== 4'(n)) begin
                    n_bad++;
                    $display("FAIL xfer_count: got %0d, required %0d", xfer_count, n);
                end
                n_cmp++;
                if (busy !== 1'b0 || mem_req !== 1'b0 || rf_we !== 1'b0) begin
                    n_bad++;
                    $display("FAIL done_outputs: busy=%b req=%b rfwe=%b, required 0/0/0", busy, mem_req, rf_we);
                end
            end else if (mem_req === 1'b1) begin
                if (mem_ack) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL extra_xfer: transfer at addr %h rf %0d, none expected", mem_addr, rf_addr);
                    end else begin
                        e = sb.pop_front();
                        if (mem_addr !== e.addr || mem_we !== e.we || rf_addr !== e.ra || busy !== 1'b1 ||
                            (e.we && (mem_wdata !== e.data || rf_we !== 1'b0)) ||
                            (!e.we && (rf_we !== 1'b1 || rf_wdata !== e.data || mem_wdata !== '0))) begin
                            n_bad++;
                            $display("FAIL xfer: got addr=%h we=%b ra=%0d wd=%h rfwe=%b rfwd=%h busy=%b, required addr=%h we=%b ra=%0d data=%h",
                                     mem_addr, mem_we, rf_addr, mem_wdata, rf_we, rf_wdata, busy,
                                     e.addr, e.we, e.ra, e.data);
                        end
                    end
                end else begin
                    stalls++;
                    n_cmp++;
                    if (rf_we !== 1'b0 || busy !== 1'b1) begin
                        n_bad++;
                        $display("FAIL stall: rfwe=%b busy=%b, required 0/1", rf_we, busy);
                    end
                end
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL no_activity: cycle %0d neither req nor done", cycle);
            end
            if (!fin) begin
                @(posedge clk); #1;
                cycle++;
            end
        end

        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no done within 200 cycles");
            apply_reset();
        end else begin
            @(posedge clk); #1;
            start = 1'b0;
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || xfer_count !== 4'(n)) begin
                n_bad++;
                $display("FAIL post_done_idle: busy=%b done=%b req=%b cnt=%0d, required 0/0/0/%0d",
                         busy, done, mem_req, xfer_count, n);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_store = 1'b0; imm8 = 8'd0; base_addr = '0; mem_ack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset_held");
        reset = 1'b0;
        @(posedge clk); #1;
        check_all_zero("reset_released");
    endtask

    task automatic test_sm_basic();
        run_seq(1'b1, 8'h29, 16'h0100, 0, 0, 1'b0, 4);
    endtask

    task automatic test_lm_wrap();
        run_seq(1'b0, 8'hFF, 16'hFFFE, 0, 0, 1'b0, 9);
    endtask

    task automatic test_lm_stall();
        run_seq(1'b0, 8'h81, 16'h0040, 2, 0, 1'b0, 5);
    endtask

    task automatic test_zero_list();
        run_seq(1'b1, 8'h00, 16'h1234, 0, 0, 1'b0, 1);
    endtask

    task automatic test_start_held();
        run_seq(1'b1, 8'h0C, 16'h0300, 0, 0, 1'b1, 3);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b0; imm8 = 8'h0F; base_addr = 16'h0200; mem_ack = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; mem_ack = 1'b1;
        #1;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_addr !== 3'd0 || mem_addr !== 16'h0200 || rf_wdata !== 16'hA200) begin
            n_bad++;
            $display("FAIL rmid_first: rfwe=%b ra=%0d addr=%h rfwd=%h, required 1/0/0200/a200",
                     rf_we, rf_addr, mem_addr, rf_wdata);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; reset = 1'b1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b1 || rf_addr !== 3'd1 || mem_addr !== 16'h0201) begin
            n_bad++;
            $display("FAIL rmid_second: req=%b ra=%0d addr=%h, required 1/1/0201", mem_req, rf_addr, mem_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_all_zero("after_mid_reset");
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_sweep();
        for (int i = 0; i < 1000; i++) begin
            run_seq(1'($urandom), 8'($urandom), AW'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 50), ($urandom_range(0, 9) == 0), -1);
        end
    endtask

    task automatic test_back_to_back();
        run_seq(1'b0, 8'h10, 16'h0010, 0, 0, 1'b0, 2);
        run_seq(1'b1, 8'h60, 16'h0020, 0, 0, 1'b0, 3);
    endtask

    initial begin
        test_reset();
        test_sm_basic();
        test_lm_wrap();
        test_lm_stall();
        test_zero_list();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
